// File: rtl/mem_load_stage_pkg.sv
// Shared constants and types for the EXE/MEM boundary.
// Selects are one-hot; the constants give each function's bit position.
package mem_load_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  // sel_wbdata bit positions
  localparam int SEL_ALU   = 0;
  localparam int SEL_EXT   = 1;
  localparam int SEL_MERGE = 2;
  localparam int SEL_LINK  = 3;

  // lubhw_con bit positions
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;

  // onehot: LWL offsets start at OH_LWL0, LWR offsets at OH_LWR0
  localparam int OH_LWL0 = 0;
  localparam int OH_LWR0 = 4;

  typedef struct packed {
    logic [31:0] aluout;
    logic [3:0]  sel;
    logic [4:0]  lubhw;
    logic [7:0]  onehot;
    logic [31:0] pc;
    logic [4:0]  regnum;
    logic [31:0] rt_old;
  } m_req_t;

endpackage

// File: rtl/mem_load_stage_if.sv
// EXE-to-MEM request, data-memory read word and MEM-to-WB result bus.
interface mem_load_stage_if;
  logic        exe_valid;
  logic        mem_allowin;
  logic        wb_allowin;
  logic [31:0] aluout_in;
  logic [3:0]  sel_wbdata_in;
  logic [4:0]  lubhw_con_in;
  logic [7:0]  onehot_in;
  logic [31:0] pc_in;
  logic [4:0]  regnum_in;
  logic [31:0] rt_old_in;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_regnum;
  logic [31:0] wb_pc;
  logic        wb_rf_we;

  modport master (
    output exe_valid, wb_allowin, aluout_in, sel_wbdata_in, lubhw_con_in,
           onehot_in, pc_in, regnum_in, rt_old_in, dm_rdata,
    input  mem_allowin, wb_valid, wb_data, wb_regnum, wb_pc, wb_rf_we
  );

  modport slave (
    input  exe_valid, wb_allowin, aluout_in, sel_wbdata_in, lubhw_con_in,
           onehot_in, pc_in, regnum_in, rt_old_in, dm_rdata,
    output mem_allowin, wb_valid, wb_data, wb_regnum, wb_pc, wb_rf_we
  );
endinterface

// File: rtl/mem_load_stage_load_align.sv
// Combinational load extension (LB/LBU/LH/LHU/LW) and LWL/LWR merge.
module load_align
  import mem_load_stage_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  a,
  input  logic [31:0] rt_old,
  input  logic [4:0]  lubhw,
  input  logic [7:0]  onehot,
  output logic [31:0] ext_data,
  output logic [31:0] merge_data
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = rword[{a, 3'b000} +: 8];
  assign h = rword[{a[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = '0;
    case (lubhw)
      5'b1 << LD_LB:  ext_data = {{24{b[7]}}, b};
      5'b1 << LD_LBU: ext_data = {24'd0, b};
      5'b1 << LD_LH:  ext_data = {{16{h[15]}}, h};
      5'b1 << LD_LHU: ext_data = {16'd0, h};
      5'b1 << LD_LW:  ext_data = rword;
      default:        ext_data = '0;
    endcase
  end

  // LWL fills from the top, LWR from the bottom; the offset comes from onehot
  always_comb begin
    merge_data = '0;
    case (onehot)
      8'b1 << (OH_LWL0 + 0): merge_data = {rword[7:0],  rt_old[23:0]};
      8'b1 << (OH_LWL0 + 1): merge_data = {rword[15:0], rt_old[15:0]};
      8'b1 << (OH_LWL0 + 2): merge_data = {rword[23:0], rt_old[7:0]};
      8'b1 << (OH_LWL0 + 3): merge_data = rword;
      8'b1 << (OH_LWR0 + 0): merge_data = rword;
      8'b1 << (OH_LWR0 + 1): merge_data = {rt_old[31:24], rword[31:8]};
      8'b1 << (OH_LWR0 + 2): merge_data = {rt_old[31:16], rword[31:16]};
      8'b1 << (OH_LWR0 + 3): merge_data = {rt_old[31:8],  rword[31:24]};
      default:               merge_data = '0;
    endcase
  end
endmodule

// File: rtl/mem_load_stage.sv
// MEM pipeline stage: latches EXE, captures the synchronous SRAM word,
// aligns loads and presents a registered write-back result.
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_load_stage_if.slave bus
);
  m_req_t      m_q, m_d;
  logic        m_valid, m_first, m_load;
  logic [31:0] hold, rword, ext_data, merge_data, result;
  logic        wb_valid_q, wb_rf_we_q;
  logic [31:0] wb_data_q, wb_pc_q;
  logic [4:0]  wb_regnum_q;

  assign bus.mem_allowin = !m_valid || bus.wb_allowin;
  assign m_load          = bus.exe_valid && bus.mem_allowin;

  assign m_d = '{aluout: bus.aluout_in, sel: bus.sel_wbdata_in,
                 lubhw: bus.lubhw_con_in, onehot: bus.onehot_in,
                 pc: bus.pc_in, regnum: bus.regnum_in, rt_old: bus.rt_old_in};

  // The SRAM word is only present in M's first cycle; a stall captures it once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_first <= 1'b0;
      hold    <= '0;
      m_q     <= '{pc: RESET_PC, default: '0};
    end else if (m_load) begin
      m_q     <= m_d;
      m_valid <= 1'b1;
      m_first <= 1'b1;
    end else begin
      if (m_valid && bus.wb_allowin) m_valid <= 1'b0;
      if (m_valid && m_first && !bus.wb_allowin) begin
        hold    <= bus.dm_rdata;
        m_first <= 1'b0;
      end
    end
  end

  assign rword = m_first ? bus.dm_rdata : hold;

  load_align u_align (
    .rword      (rword),
    .a          (m_q.aluout[1:0]),
    .rt_old     (m_q.rt_old),
    .lubhw      (m_q.lubhw),
    .onehot     (m_q.onehot),
    .ext_data   (ext_data),
    .merge_data (merge_data)
  );

  // Anything other than exactly one select bit yields zero
  always_comb begin
    result = '0;
    if      (m_q.sel == (4'b1 << SEL_ALU))   result = m_q.aluout;
    else if (m_q.sel == (4'b1 << SEL_EXT))   result = ext_data;
    else if (m_q.sel == (4'b1 << SEL_MERGE)) result = merge_data;
    else if (m_q.sel == (4'b1 << SEL_LINK))  result = m_q.pc + 32'd8;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_regnum_q <= '0;
      wb_pc_q     <= RESET_PC;
      wb_rf_we_q  <= 1'b0;
    end else if (bus.wb_allowin) begin
      wb_valid_q  <= m_valid;
      wb_data_q   <= result;
      wb_regnum_q <= m_q.regnum;
      wb_pc_q     <= m_q.pc;
      wb_rf_we_q  <= m_valid && (m_q.regnum != 5'd0);
    end
  end

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_regnum = wb_regnum_q;
  assign bus.wb_pc     = wb_pc_q;
  assign bus.wb_rf_we  = wb_rf_we_q;
endmodule

// File: tb/tb_mem_load_stage.sv
// Self-checking bench for mem_load_stage: directed load/merge/stall/reset
// cases plus randomized traffic against a transaction-level model.
module tb_mem_load_stage;
  import mem_load_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_load_stage_if bus();

  mem_load_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] aluout;
    logic [3:0]  sel;
    logic [4:0]  lubhw;
    logic [7:0]  onehot;
    logic [31:0] pc;
    logic [4:0]  regnum;
    logic [31:0] rt_old;
    logic [31:0] word;
  } instr_t;

  // Expected write-back value straight from the load/merge rules
  function automatic logic [31:0] ref_result(input instr_t t);
    int a = int'(t.aluout[1:0]);
    int k = -1;
    logic [31:0] byt, half, r;
    byt  = (t.word >> (8 * a)) & 32'hFF;
    half = (t.word >> (16 * (a / 2))) & 32'hFFFF;
    r = 32'd0;
    case (t.sel)
      4'b0001: r = t.aluout;
      4'b0010: case (t.lubhw)
        5'b00001: r = (byt ^ 32'h80) - 32'h80;
        5'b00010: r = byt;
        5'b00100: r = (half ^ 32'h8000) - 32'h8000;
        5'b01000: r = half;
        5'b10000: r = t.word;
        default:  r = 32'd0;
      endcase
      4'b0100: begin
        for (int i = 0; i < 8; i++) if (t.onehot == 8'(1 << i)) k = i;
        if (k >= 0 && k < 4)
          r = (t.word << (8 * (3 - k))) | (t.rt_old & ((32'h1 << (8 * (3 - k))) - 32'h1));
        else if (k >= 4)
          r = (t.word >> (8 * (k - 4))) | (t.rt_old & ~(32'hFFFF_FFFF >> (8 * (k - 4))));
      end
      4'b1000: r = t.pc + 32'd8;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic instr_t mk(input logic [3:0] sel, input logic [4:0] lubhw,
                                input logic [7:0] onehot, input logic [31:0] aluout,
                                input logic [31:0] word, input logic [31:0] rt_old,
                                input logic [31:0] pc, input logic [4:0] regnum);
    instr_t t;
    t.sel = sel; t.lubhw = lubhw; t.onehot = onehot; t.aluout = aluout;
    t.word = word; t.rt_old = rt_old; t.pc = pc; t.regnum = regnum;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.sel    = 4'(1 << $urandom_range(0, 3));
    t.lubhw  = 5'(1 << $urandom_range(0, 4));
    t.onehot = 8'(1 << $urandom_range(0, 7));
    t.aluout = $urandom;
    t.pc     = $urandom & 32'hFFFF_FFFC;
    t.regnum = 5'($urandom_range(0, 31));
    t.rt_old = $urandom;
    t.word   = $urandom;
    return t;
  endfunction

  task automatic drive(input instr_t t, input logic v);
    bus.exe_valid     = v;
    bus.aluout_in     = t.aluout;
    bus.sel_wbdata_in = t.sel;
    bus.lubhw_con_in  = t.lubhw;
    bus.onehot_in     = t.onehot;
    bus.pc_in         = t.pc;
    bus.regnum_in     = t.regnum;
    bus.rt_old_in     = t.rt_old;
  endtask

  // Issue one instruction with no stall; returns at posedge+1 after W loads
  task automatic one_shot(input instr_t t);
    bus.wb_allowin = 1'b1;
    drive(t, 1'b1);
    @(posedge clk); #1;
    bus.exe_valid = 1'b0;
    bus.dm_rdata  = t.word;
    @(posedge clk); #1;
    bus.dm_rdata  = $urandom;
  endtask

  task automatic idle(input int n);
    bus.exe_valid  = 1'b0;
    bus.wb_allowin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    instr_t z;
    z = mk(4'd0, 5'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    rst_n = 1'b0;
    drive(z, 1'b0);
    bus.wb_allowin = 1'b0;
    bus.dm_rdata   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b want 0", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
    checks++; if (bus.wb_regnum !== 5'd0) begin errors++; $display("FAIL reset_wb_regnum got %0d want 0", bus.wb_regnum); end
    checks++; if (bus.wb_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_wb_pc got %h want bfc00000", bus.wb_pc); end
    checks++; if (bus.wb_rf_we !== 1'b0) begin errors++; $display("FAIL reset_wb_rf_we got %0b want 0", bus.wb_rf_we); end
    checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL reset_mem_allowin got %0b want 1", bus.mem_allowin); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_extend();
    one_shot(mk(4'b0010, 5'b00001, 8'd0, 32'h1000_0003, 32'h80FF_1234, 32'd0, 32'h100, 5'd2));
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got v=%0b %h want ffffff80", bus.wb_valid, bus.wb_data); end
    one_shot(mk(4'b0010, 5'b00010, 8'd0, 32'h1000_0003, 32'h80FF_1234, 32'd0, 32'h104, 5'd2));
    checks++; if (bus.wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", bus.wb_data); end
    one_shot(mk(4'b0010, 5'b00100, 8'd0, 32'h1000_0002, 32'h8001_0000, 32'd0, 32'h108, 5'd3));
    checks++; if (bus.wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", bus.wb_data); end
    one_shot(mk(4'b0010, 5'b01000, 8'd0, 32'h1000_0000, 32'h8001_0000, 32'd0, 32'h10C, 5'd3));
    checks++; if (bus.wb_data !== 32'h0000_0000) begin errors++; $display("FAIL lhu got %h want 00000000", bus.wb_data); end
  endtask

  task automatic test_merge();
    one_shot(mk(4'b0100, 5'd0, 8'b0000_0010, 32'h2000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'h200, 5'd4));
    checks++; if (bus.wb_data !== 32'hCCDD_3344) begin errors++; $display("FAIL lwl_k1 got %h want ccdd3344", bus.wb_data); end
    one_shot(mk(4'b0100, 5'd0, 8'b0100_0000, 32'h2000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h204, 5'd4));
    checks++; if (bus.wb_data !== 32'h1122_AABB) begin errors++; $display("FAIL lwr_k2 got %h want 1122aabb", bus.wb_data); end
    one_shot(mk(4'b0000, 5'b10000, 8'd1, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h208, 5'd4));
    checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL sel_zero got %h want 0", bus.wb_data); end
    one_shot(mk(4'b0011, 5'b10000, 8'd1, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h20C, 5'd4));
    checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL sel_multi got %h want 0", bus.wb_data); end
  endtask

  task automatic test_link();
    one_shot(mk(4'b1000, 5'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'hBFC0_0010, 5'd31));
    checks++; if (bus.wb_data !== 32'hBFC0_0018) begin errors++; $display("FAIL link_data got %h want bfc00018", bus.wb_data); end
    checks++; if (bus.wb_rf_we !== 1'b1 || bus.wb_regnum !== 5'd31) begin errors++; $display("FAIL link_we31 got we=%0b rn=%0d want 1/31", bus.wb_rf_we, bus.wb_regnum); end
    one_shot(mk(4'b1000, 5'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'hBFC0_0010, 5'd0));
    checks++; if (bus.wb_rf_we !== 1'b0 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL link_we0 got we=%0b v=%0b want 0/1", bus.wb_rf_we, bus.wb_valid); end
  endtask

  task automatic test_stall();
    instr_t i1, i2;
    i1 = mk(4'b0001, 5'd0, 8'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h300, 5'd5);
    i2 = mk(4'b0010, 5'b10000, 8'd0, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0, 32'h304, 5'd7);
    idle(2);
    drive(i1, 1'b1);
    @(posedge clk); #1;
    drive(i2, 1'b1);
    bus.dm_rdata = i1.word;
    @(posedge clk); #1;
    bus.exe_valid  = 1'b0;
    bus.wb_allowin = 1'b0;
    bus.dm_rdata   = 32'hDEAD_BEEF;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_pre got v=%0b %h want 1/12345678", bus.wb_valid, bus.wb_data); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus.dm_rdata = 32'h0;
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1234_5678 || bus.wb_regnum !== 5'd5 || bus.mem_allowin !== 1'b0) begin
        errors++; $display("FAIL stall_frozen c=%0d got v=%0b %h rn=%0d allow=%0b", c, bus.wb_valid, bus.wb_data, bus.wb_regnum, bus.mem_allowin);
      end
    end
    bus.wb_allowin = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hDEAD_BEEF || bus.wb_regnum !== 5'd7) begin errors++; $display("FAIL stall_release got v=%0b %h rn=%0d want 1/deadbeef/7", bus.wb_valid, bus.wb_data, bus.wb_regnum); end
  endtask

  task automatic test_reset_mid_stall();
    instr_t t;
    t = mk(4'b0001, 5'd0, 8'd0, 32'hCAFE_0000, 32'h0, 32'h0, 32'h400, 5'd9);
    idle(2);
    drive(t, 1'b1);
    @(posedge clk); #1;
    bus.exe_valid  = 1'b0;
    bus.wb_allowin = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_stall got v=%0b pc=%h want 0/bfc00000", bus.wb_valid, bus.wb_pc); end
    checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL rst_stall_allowin got %0b want 1", bus.mem_allowin); end
    rst_n = 1'b1;
    bus.wb_allowin = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_dropped got v=%0b want 0", bus.wb_valid); end
  endtask

  // Random traffic: model tracks one M slot and one W slot per the handshake
  task automatic test_traffic(input int n, input int pct_exe, input int pct_allow);
    instr_t cur, m_i, w_i;
    bit m_full = 0, w_valid = 0, first = 0, ev, al;
    idle(2);
    m_i = rand_instr();
    w_i = m_i;
    for (int c = 0; c < n; c++) begin
      cur = rand_instr();
      ev  = ($urandom_range(0, 99) < pct_exe);
      al  = ($urandom_range(0, 99) < pct_allow);
      drive(cur, ev);
      bus.wb_allowin = al;
      bus.dm_rdata   = first ? m_i.word : $urandom;
      #1;
      checks++; if (bus.mem_allowin !== (!m_full || al)) begin errors++; $display("FAIL trf_allowin c=%0d got %0b want %0b", c, bus.mem_allowin, (!m_full || al)); end
      @(posedge clk);
      if (al) begin w_valid = m_full; w_i = m_i; end
      if (ev && (!m_full || al)) begin m_i = cur; m_full = 1; first = 1; end
      else begin if (al) m_full = 0; first = 0; end
      #1;
      checks++; if (bus.wb_valid !== w_valid) begin errors++; $display("FAIL trf_valid c=%0d got %0b want %0b", c, bus.wb_valid, w_valid); end
      checks++; if (bus.wb_rf_we !== (w_valid && w_i.regnum != 5'd0)) begin errors++; $display("FAIL trf_rf_we c=%0d got %0b", c, bus.wb_rf_we); end
      if (w_valid) begin
        checks++;
        if (bus.wb_data !== ref_result(w_i) || bus.wb_regnum !== w_i.regnum || bus.wb_pc !== w_i.pc) begin
          errors++; $display("FAIL trf_data c=%0d got %h/%0d/%h want %h/%0d/%h", c, bus.wb_data, bus.wb_regnum, bus.wb_pc, ref_result(w_i), w_i.regnum, w_i.pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_merge();
    test_link();
    test_stall();
    test_reset_mid_stall();
    test_traffic(60, 100, 100);
    test_traffic(300, 70, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_load_stage.md
# mem_load_stage

Memory-access stage of the 5-stage pipeline, sitting between EXE and register write-back. It latches EXE's registered outputs and takes the synchronous data-memory read word, which arrives one cycle after EXE drives `dm_addr`. It performs load extension (LB/LBU/LH/LHU/LW) and LWL/LWR merging. It presents a registered write-back result under a valid/allowin handshake, and holds the read word across downstream stalls.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, reset value of `wb_pc`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `exe_valid`  in  1  EXE holds a valid instruction.
- `mem_allowin`  out  1  stage can accept; equals `!m_valid || wb_allowin`.
- `wb_allowin`  in  1  write-back consumer accepts this cycle.
- `aluout_in`  in  32  ALU result / effective address.
- `sel_wbdata_in`  in  4  one-hot source select: b0 ALU, b1 extended load, b2 LWL/LWR merge, b3 link (PC+8).
- `lubhw_con_in`  in  5  one-hot: b0 LB, b1 LBU, b2 LH, b3 LHU, b4 LW.
- `onehot_in`  in  8  b[3:0] LWL with addr[1:0] = 0..3; b[7:4] LWR with addr[1:0] = 0..3.
- `pc_in`  in  32  instruction PC.
- `regnum_in`  in  5  destination GPR.
- `rt_old_in`  in  32  old rt value for merge.
- `dm_rdata`  in  32  SRAM read word, valid only in the first M cycle.
- `wb_valid`  out  1  registered result valid.
- `wb_data`  out  32  registered write-back data.
- `wb_regnum`  out  5  registered destination.
- `wb_pc`  out  32  registered PC (debug trace).
- `wb_rf_we`  out  1  `wb_valid && wb_regnum != 0`.

## Operation
- The M register loads `aluout_in`, the selects, `pc_in`, `regnum_in` and `rt_old_in` when `exe_valid && mem_allowin`. At the same time `m_valid <= 1` and `m_first <= 1`.
- If M is not loading but is consumed (`m_valid && wb_allowin`), then `m_valid <= 0`.
- Read-word select: `rword = m_first ? dm_rdata : hold`.
- Hold buffer: when `m_valid && m_first && !wb_allowin`, load `hold <= dm_rdata` and clear `m_first`. `hold` is never reloaded while the same instruction stalls.
- Extension uses byte `b = rword[8*a+7:8*a]` and half `h = rword[16*a[1]+15:16*a[1]]`, where `a = aluout[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes `rword`.
- LWL at offset k: `{rword[8k+7:0], rt_old[23-8k:0]}`; at k=3 the result is `rword`.
- LWR at offset k: `{rt_old[31:32-8k], rword[31:8k]}`; at k=0 the result is `rword`.
- Link result: `pc + 32'd8`.
- `sel_wbdata` all-zero or multi-hot: result is 0. Verification checks this case as illegal.
- The W register loads from M when `wb_allowin`; `wb_valid <= m_valid`.

## Timing
- Reset, synchronous: `m_valid=0`, `m_first=0`, `hold=0`, `wb_valid=0`, `wb_data=0`, `wb_regnum=0`, `wb_pc=RESET_PC`, `wb_rf_we=0`.
- Latency: EXE-to-M register edge, then one cycle, then the M-to-W edge. `wb_*` valid one cycle after M loads when there is no stall.
- Stall of N cycles: `wb_*` unchanged. On release the result uses `hold`, which must equal the first-cycle `dm_rdata` even if `dm_rdata` has since changed.
- Back-to-back: with `wb_allowin=1` continuously, throughput is one per cycle and `m_first` re-arms on every load.
- A simultaneous consume and load replaces M, sets `m_first=1`, and leaves `hold` untouched.
- Reset mid-stall drops the held instruction; `wb_valid=0` on the next cycle.

## Structure
- Shared package: the `sel_wbdata`, `lubhw_con` and `onehot` bit-position constants, and `RESET_PC`. EXE uses the same package.
- One sub-module, `load_align`: combinational extension and merge from `rword`, `a`, `rt_old` and the selects.

## Test plan
- LB at addr 0x...03, `dm_rdata=32'h80FF_1234`, no stall: `wb_data=32'hFFFF_FF80` one cycle after M load; LBU gives `32'h0000_0080`.
- LH at addr 0x...02, `dm_rdata=32'h8001_0000`: `wb_data=32'hFFFF_8001`. LHU at addr 0x...00, same word: `32'h0000_0000`.
- LWL k=1, `rword=32'hAABBCCDD`, `rt_old=32'h11223344`: `wb_data=32'hCCDD3344`. LWR k=2: `32'h1122AABB`.
- LW, `dm_rdata=32'hDEADBEEF` in the first M cycle, then `32'h0`, `wb_allowin=0` for 3 cycles: `wb_*` frozen, then `wb_data=32'hDEADBEEF`.
- Link with `pc=32'hBFC0_0010`, `regnum=31`: `wb_data=32'hBFC0_0018`, `wb_rf_we=1`. With `regnum=0`: `wb_rf_we=0`.
- Reset asserted during a stall with M valid: next cycle `wb_valid=0`, `wb_pc=32'hBFC0_0000`, `mem_allowin=1`.
